// File: rtl/temp_sampler_if.sv
// Signal bundle between the temperature sampler, its SPI ADC and the downstream comparator.
// The sampler is the SPI master, so it takes the master modport; the environment takes slave.
interface temp_sampler_if;
    logic        sample_tick;
    logic        adc_sdo;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] temp;
    logic        temp_valid;
    logic        busy;

    modport master (
        input  sample_tick,
        input  adc_sdo,
        output adc_cs_n,
        output adc_sclk,
        output temp,
        output temp_valid,
        output busy
    );

    modport slave (
        output sample_tick,
        output adc_sdo,
        input  adc_cs_n,
        input  adc_sclk,
        input  temp,
        input  temp_valid,
        input  busy
    );
endinterface

// File: rtl/temp_sampler.sv
// Reads a 12-bit SPI temperature ADC once per sample_tick and publishes the mean of
// 2^AVG_LOG2 consecutive conversions on temp, strobing temp_valid on each update.
module temp_sampler #(
    parameter int SCLK_DIV = 4,
    parameter int AVG_LOG2 = 3
) (
    input  logic           clk,
    input  logic           rst,
    temp_sampler_if.master bus
);
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [7:0]       DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       div_reg, div_next;
    logic [4:0]       half_reg, half_next;
    logic             cs_n_reg, cs_n_next;
    logic             sclk_reg, sclk_next;
    logic             div_done;
    logic             shift_en;
    logic             sample_done;
    logic [11:0]      shift_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_reg;
    logic [11:0]      temp_reg;
    logic             temp_valid_reg;

    assign div_done = (div_reg == DIV_LAST);
    assign acc_sum  = acc_reg + ACC_W'(shift_reg);

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        half_next   = half_reg;
        shift_en    = 1'b0;
        sample_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.sample_tick) begin
                    state_next = SETUP;
                    div_next   = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    state_next = SHIFT;
                    div_next   = '0;
                    half_next  = '0;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            SHIFT: begin
                // Even half-periods are SCLK low; their last clock is the SCLK rising edge.
                if (div_done) begin
                    div_next = '0;
                    shift_en = ~half_reg[0];
                    if (half_reg == 5'd31) begin
                        state_next  = HOLD;
                        sample_done = 1'b1;
                    end else begin
                        half_next = half_reg + 5'd1;
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            HOLD: begin
                if (div_done) begin
                    state_next = IDLE;
                    div_next   = '0;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        cs_n_next = !((state_next == SETUP) || (state_next == SHIFT));
        sclk_next = (state_next != SHIFT) || half_next[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            half_reg  <= '0;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            half_reg  <= half_next;
            cs_n_reg  <= cs_n_next;
            sclk_reg  <= sclk_next;
        end
    end

    // All 16 bits are shifted through a 12-bit register, so the 4 leading bits fall off the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg      <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            temp_reg       <= '0;
            temp_valid_reg <= 1'b0;
        end else begin
            temp_valid_reg <= 1'b0;
            if (shift_en) begin
                shift_reg <= {shift_reg[10:0], bus.adc_sdo};
            end
            if (sample_done) begin
                if (cnt_reg == CNT_LAST) begin
                    temp_reg       <= acc_sum[AVG_LOG2 +: 12];
                    temp_valid_reg <= 1'b1;
                    acc_reg        <= '0;
                    cnt_reg        <= '0;
                end else begin
                    acc_reg <= acc_sum;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign bus.adc_cs_n   = cs_n_reg;
    assign bus.adc_sclk   = sclk_reg;
    assign bus.temp       = temp_reg;
    assign bus.temp_valid = temp_valid_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: doc/temp_sampler.md
TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4, giving system clocks per SCLK half-period (legal range 2..255).
REQ-002 SHALL have parameter AVG_LOG2, default 3, giving log2 of samples averaged per output (legal range 0..4).
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port sample_tick, input, 1 bit, a one-cycle request to start one ADC conversion frame.
REQ-006 SHALL have port adc_sdo, input, 1 bit, serial data from a 12-bit SPI ADC, MSB first.
REQ-007 SHALL have port adc_cs_n, output, 1 bit, ADC chip select, active low.
REQ-008 SHALL have port adc_sclk, output, 1 bit, ADC serial clock, idle high.
REQ-009 SHALL have port temp, output, 12 bits, averaged raw temperature code (the downstream comparator input).
REQ-010 SHALL have port temp_valid, output, 1 bit, a one-cycle strobe when temp updates.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, SHIFT and HOLD.
REQ-013 IDLE: on sample_tick=1 SHALL go to SETUP next cycle with adc_cs_n=0; sample_tick is ignored in all other states.
REQ-014 SETUP SHALL last SCLK_DIV clocks with adc_sclk=1, then enter SHIFT.
REQ-015 SHIFT SHALL produce exactly 16 SCLK periods (first half low, second half high, each half SCLK_DIV clocks).
REQ-016 SHIFT SHALL sample adc_sdo on the clk edge where adc_sclk goes 0->1.
REQ-017 SHALL discard the first 4 sampled bits and shift rising edges 5..16 into a 12-bit sample register, MSB first.
REQ-018 After the 16th high half, SHALL enter HOLD with adc_cs_n=1, adc_sclk=1 for SCLK_DIV clocks, then return to IDLE.
REQ-019 Frame length SHALL be SCLK_DIV*34 clocks from SETUP entry to IDLE re-entry (136 at default); busy is high for exactly this span.
REQ-020 On HOLD entry SHALL add the 12-bit sample to a (12+AVG_LOG2)-bit accumulator and increment a sample counter; no overflow is possible.
REQ-021 When the counter reaches 2^AVG_LOG2, SHALL in the same cycle load temp = accumulator >> AVG_LOG2 (truncating), pulse temp_valid for one cycle, and clear the accumulator and counter.
REQ-022 temp SHALL hold its value between updates; temp_valid SHALL never be high for two consecutive cycles.
REQ-023 With AVG_LOG2=0, every frame SHALL update temp directly with the sample.
REQ-024 A sample_tick coincident with the cycle that returns to IDLE SHALL be ignored; only a tick seen while in IDLE starts a frame.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, adc_cs_n=1, adc_sclk=1, temp=0, temp_valid=0, busy=0, and clear the accumulator, counter and shift register.
REQ-026 Reset mid-frame SHALL abandon the partial sample and the partial average; the first temp_valid after release requires 2^AVG_LOG2 complete new frames.

Verification
REQ-027 Bench SHALL drive an ADC model returning 3625 (0xE29) for 8 frames -> exactly one temp_valid, temp=3625, at the end of frame 8.
REQ-028 Bench SHALL drive samples 1000..1007 -> temp=1003 (8028/8 truncated).
REQ-029 Bench SHALL drive 8 samples of 4095 -> temp=4095 with no wrap; then 8 samples of 0 -> temp=0.
REQ-030 Bench SHALL pulse sample_tick every 40 clocks at default parameters -> one frame per 136 clocks; extra ticks ignored; adc_sclk shows exactly 16 rising edges per adc_cs_n low window.
REQ-031 Bench SHALL assert rst at SHIFT bit 9 of frame 5 -> adc_cs_n=1 and adc_sclk=1 immediately; temp=0; the next temp_valid only after 8 further full frames.
